// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard/stall control slice:
//   REG_ADDR_W        width of a register address (8 architectural registers)
//   LOAD_STALL_CYCLES total cycles a load-use hazard holds the front end
//   STAT_W            width of each statistics counter
//   CNT_W             width of the stall-cycle down-counter
//   hz_state_e        FSM state type (RUN, LU_STALL)
//   src_hit()         one source-operand vs. destination comparison
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_ADDR_W        = 3;
    localparam int LOAD_STALL_CYCLES = 2;
    localparam int STAT_W            = 16;
    localparam int CNT_W             = 2;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_e;

    // A source only matters when the instruction really reads it; every
    // register address (including 0) takes part in the comparison.
    function automatic logic src_hit(input logic                  used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value.
// Ports:
//   clk    in   rising-edge clock
//   clr_n  in   synchronous active-low clear (wins over en)
//   en     in   count one when high
//   count  out  current count (WIDTH bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!clr_n) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Detects load-use hazards between the instruction in ID and a load in ID/EX
// and sequences the resulting stall, branch squash and memory freeze.
// A load's data is only forwarded from MEM_WB, so a dependent instruction is
// held for LOAD_STALL_CYCLES cycles: the detecting RUN cycle plus the cycles
// counted down in LU_STALL.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   src1, src2                  ID source register addresses
//   src1_used, src2_used        ID instruction reads src1 / src2
//   ID_EX_RD                    ID/EX destination register
//   ID_EX_readEN, ID_EX_EN      ID/EX is a memory read / writes a register
//   mem_busy                    data memory not ready (freeze everything)
//   branch_taken                EX resolved a taken branch
//   pc_hold, IF_ID_hold         hold PC / IF_ID
//   ID_EX_flush, IF_ID_flush    insert bubble into ID_EX / IF_ID
//   pipe_freeze                 hold ID_EX, EX_MEM, MEM_WB
//   stall_active                load-use stall in progress
//   stall_cycles, bubble_count  statistics (tied to 0 unless enabled)
//
// Build option: define HAZARD_STALL_STATS_EN to compile in the statistics
// counters; otherwise both statistics ports read 16'h0000.
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src1_used,
    input  logic                  src2_used,
    input  logic [REG_ADDR_W-1:0] ID_EX_RD,
    input  logic                  ID_EX_readEN,
    input  logic                  ID_EX_EN,
    input  logic                  mem_busy,
    input  logic                  branch_taken,
    output logic                  pc_hold,
    output logic                  IF_ID_hold,
    output logic                  ID_EX_flush,
    output logic                  IF_ID_flush,
    output logic                  pipe_freeze,
    output logic                  stall_active,
    output logic [STAT_W-1:0]     stall_cycles,
    output logic [STAT_W-1:0]     bubble_count
);

    // Counter value loaded on entry to LU_STALL: the detecting RUN cycle is
    // already the first stall cycle.
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    assign hazard = ID_EX_readEN && ID_EX_EN &&
                    (src_hit(src1_used, src1, ID_EX_RD) ||
                     src_hit(src2_used, src2, ID_EX_RD));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_hold      = 1'b0;
        IF_ID_hold   = 1'b0;
        ID_EX_flush  = 1'b0;
        IF_ID_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        stall_active = 1'b0;

        if (!rst_n) begin
            // Outputs stay quiet while reset is asserted.
            state_d = RUN;
            cnt_d   = '0;
        end else if (mem_busy) begin
            // Freeze dominates; EX keeps any branch, so it is seen again later.
            pipe_freeze  = 1'b1;
            pc_hold      = 1'b1;
            IF_ID_hold   = 1'b1;
            stall_active = (state_q == LU_STALL);
        end else if (branch_taken) begin
            // Squash the younger instructions; a pending stall is moot.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (state_q == LU_STALL) begin
            // Hazard inputs are deliberately not looked at here.
            pc_hold      = 1'b1;
            IF_ID_hold   = 1'b1;
            ID_EX_flush  = 1'b1;
            stall_active = 1'b1;
            cnt_d        = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            state_d      = (cnt_d == '0) ? RUN : LU_STALL;
        end else if (hazard) begin
            pc_hold      = 1'b1;
            IF_ID_hold   = 1'b1;
            ID_EX_flush  = 1'b1;
            stall_active = 1'b1;
            state_d      = LU_STALL;
            cnt_d        = STALL_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic stall_cnt_en;
    logic bubble_cnt_en;

    // A frozen cycle is not a stall cycle of its own.
    assign stall_cnt_en  = stall_active && !mem_busy;
    assign bubble_cnt_en = ID_EX_flush;

    sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (stall_cnt_en),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(STAT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (bubble_cnt_en),
        .count (bubble_count)
    );
`else
    assign stall_cycles = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed scenarios with hand-written expectations plus a randomized run
// checked against a behavioural model that tracks "stall cycles remaining".
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

`ifdef HAZARD_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int STALL_LEN = 2;
    localparam int SAT_MAX   = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  src1 = '0, src2 = '0, ID_EX_RD = '0;
    logic        src1_used = 1'b0, src2_used = 1'b0;
    logic        ID_EX_readEN = 1'b0, ID_EX_EN = 1'b0;
    logic        mem_busy = 1'b0, branch_taken = 1'b0;
    logic        pc_hold, IF_ID_hold, ID_EX_flush, IF_ID_flush, pipe_freeze, stall_active;
    logic [15:0] stall_cycles, bubble_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_left   = 0;
    int m_stalls = 0;
    int m_bubbles = 0;

    hazard_stall_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src1         (src1),
        .src2         (src2),
        .src1_used    (src1_used),
        .src2_used    (src2_used),
        .ID_EX_RD     (ID_EX_RD),
        .ID_EX_readEN (ID_EX_readEN),
        .ID_EX_EN     (ID_EX_EN),
        .mem_busy     (mem_busy),
        .branch_taken (branch_taken),
        .pc_hold      (pc_hold),
        .IF_ID_hold   (IF_ID_hold),
        .ID_EX_flush  (ID_EX_flush),
        .IF_ID_flush  (IF_ID_flush),
        .pipe_freeze  (pipe_freeze),
        .stall_active (stall_active),
        .stall_cycles (stall_cycles),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    // Observed control outputs packed as
    // {pc_hold, IF_ID_hold, ID_EX_flush, IF_ID_flush, pipe_freeze, stall_active}
    wire [5:0] obs = {pc_hold, IF_ID_hold, ID_EX_flush, IF_ID_flush, pipe_freeze, stall_active};

    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_STALL  = 6'b111001;
    localparam logic [5:0] O_BRANCH = 6'b001100;
    localparam logic [5:0] O_FRZ_LU = 6'b110011;

    // Stimulus word: {rst_n, src1, src2, u1, u2, rd, readEN, EN, busy, br}
    function automatic logic [15:0] mk(bit r, int s1, int s2, bit u1, bit u2,
                                       int rd, bit ren, bit en, bit busy, bit br);
        return {r, 3'(s1), 3'(s2), u1, u2, 3'(rd), ren, en, busy, br};
    endfunction

    // Drive one cycle's inputs just after the edge and let them settle.
    task automatic apply(input logic [15:0] v);
        @(posedge clk);
        #1;
        {rst_n, src1, src2, src1_used, src2_used, ID_EX_RD,
         ID_EX_readEN, ID_EX_EN, mem_busy, branch_taken} = v;
        #3;
    endtask

    function automatic bit m_hazard();
        return ID_EX_readEN && ID_EX_EN &&
               ((src1_used && src1 == ID_EX_RD) || (src2_used && src2 == ID_EX_RD));
    endfunction

    function automatic logic [5:0] m_outs();
        if (!rst_n)                      return O_IDLE;
        if (mem_busy)                    return {5'b11001, m_left > 0};
        if (branch_taken)                return O_BRANCH;
        if (m_left > 0 || m_hazard())    return O_STALL;
        return O_IDLE;
    endfunction

    // Advance the model across the coming clock edge.
    task automatic m_step();
        logic [5:0] o;
        o = m_outs();
        if (!rst_n) begin
            m_left = 0; m_stalls = 0; m_bubbles = 0;
        end else if (!mem_busy) begin
            if (o[0] && m_stalls < SAT_MAX)  m_stalls++;
            if (o[3] && m_bubbles < SAT_MAX) m_bubbles++;
            if (branch_taken)     m_left = 0;
            else if (m_left > 0)  m_left--;
            else if (m_hazard())  m_left = STALL_LEN - 1;
        end
    endtask

    function automatic logic [15:0] ex_stat(int v);
        return STATS ? 16'(v) : 16'h0;
    endfunction

    task automatic test_reset();
        apply(mk(0, 3, 3, 1, 1, 3, 1, 1, 0, 0));
        total++;
        if (obs !== O_IDLE) begin
            bad++; $display("FAIL reset_hazard_in: outputs=%b required=%b", obs, O_IDLE);
        end
        m_step();
        apply(mk(0, 1, 1, 1, 1, 1, 1, 1, 1, 1));
        total++;
        if (obs !== O_IDLE) begin
            bad++; $display("FAIL reset_busy_in: outputs=%b required=%b", obs, O_IDLE);
        end
        m_step();
        apply(mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0));
        total++;
        if (obs !== O_IDLE || stall_cycles !== 16'h0 || bubble_count !== 16'h0) begin
            bad++; $display("FAIL reset_release: outputs=%b stalls=%0d bubbles=%0d required=%b 0 0",
                            obs, stall_cycles, bubble_count, O_IDLE);
        end
        m_step();
    endtask

    task automatic test_load_use();
        logic [15:0] stim [4];
        logic [5:0]  exp  [4];
        stim[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp[0] = O_IDLE;
        stim[1] = mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0); exp[1] = O_STALL;
        stim[2] = mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0); exp[2] = O_STALL;
        stim[3] = mk(1, 3, 0, 1, 0, 3, 0, 1, 0, 0); exp[3] = O_IDLE;
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL load_use cycle %0d: outputs=%b required=%b", i, obs, exp[i]);
            end
            m_step();
        end
        total++;
        if (stall_cycles !== ex_stat(2) || bubble_count !== ex_stat(2)) begin
            bad++; $display("FAIL load_use_stats: stalls=%0d bubbles=%0d required=%0d %0d",
                            stall_cycles, bubble_count, ex_stat(2), ex_stat(2));
        end
    endtask

    task automatic test_no_hazard();
        logic [15:0] stim [8];
        logic [5:0]  exp  [8];
        stim[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp[0] = O_IDLE;
        stim[1] = mk(1, 3, 0, 0, 0, 3, 1, 1, 0, 0); exp[1] = O_IDLE;  // src1 unused
        stim[2] = mk(1, 3, 0, 1, 0, 3, 0, 1, 0, 0); exp[2] = O_IDLE;  // not a load
        stim[3] = mk(1, 0, 3, 1, 0, 3, 1, 1, 0, 0); exp[3] = O_IDLE;  // src2 unused
        stim[4] = mk(1, 3, 3, 1, 1, 3, 1, 0, 0, 0); exp[4] = O_IDLE;  // no reg write
        stim[5] = mk(1, 6, 0, 1, 1, 0, 1, 1, 0, 0); exp[5] = O_STALL; // src2 hits r0
        stim[6] = mk(1, 6, 0, 1, 1, 0, 1, 1, 0, 0); exp[6] = O_STALL;
        stim[7] = mk(1, 6, 0, 1, 1, 2, 1, 1, 0, 0); exp[7] = O_IDLE;
        for (int i = 0; i < 8; i++) begin
            apply(stim[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL no_hazard cycle %0d: outputs=%b required=%b", i, obs, exp[i]);
            end
            m_step();
        end
    endtask

    task automatic test_branch();
        logic [15:0] stim [6];
        logic [5:0]  exp  [6];
        stim[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp[0] = O_IDLE;
        stim[1] = mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0); exp[1] = O_STALL;
        stim[2] = mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 1); exp[2] = O_BRANCH; // 2nd stall cycle
        stim[3] = mk(1, 3, 0, 1, 0, 3, 0, 1, 0, 0); exp[3] = O_IDLE;
        stim[4] = mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 1); exp[4] = O_BRANCH; // hazard ignored
        stim[5] = mk(1, 5, 0, 1, 0, 5, 0, 1, 0, 0); exp[5] = O_IDLE;
        for (int i = 0; i < 6; i++) begin
            apply(stim[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL branch cycle %0d: outputs=%b required=%b", i, obs, exp[i]);
            end
            m_step();
        end
        total++;
        if (stall_cycles !== ex_stat(1) || bubble_count !== ex_stat(3)) begin
            bad++; $display("FAIL branch_stats: stalls=%0d bubbles=%0d required=%0d %0d",
                            stall_cycles, bubble_count, ex_stat(1), ex_stat(3));
        end
    endtask

    task automatic test_mem_busy();
        logic [15:0] stim [7];
        logic [5:0]  exp  [7];
        stim[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp[0] = O_IDLE;
        stim[1] = mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0); exp[1] = O_STALL;
        stim[2] = mk(1, 3, 0, 1, 0, 3, 1, 1, 1, 0); exp[2] = O_FRZ_LU;
        stim[3] = mk(1, 3, 0, 1, 0, 3, 1, 1, 1, 1); exp[3] = O_FRZ_LU; // branch ignored
        stim[4] = mk(1, 3, 0, 1, 0, 3, 0, 1, 1, 0); exp[4] = O_FRZ_LU;
        stim[5] = mk(1, 3, 0, 1, 0, 3, 0, 1, 0, 0); exp[5] = O_STALL;  // remaining cycle
        stim[6] = mk(1, 3, 0, 1, 0, 3, 0, 1, 0, 0); exp[6] = O_IDLE;
        for (int i = 0; i < 7; i++) begin
            apply(stim[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL mem_busy cycle %0d: outputs=%b required=%b", i, obs, exp[i]);
            end
            m_step();
        end
        total++;
        if (stall_cycles !== ex_stat(2) || bubble_count !== ex_stat(2)) begin
            bad++; $display("FAIL mem_busy_stats: stalls=%0d bubbles=%0d required=%0d %0d",
                            stall_cycles, bubble_count, ex_stat(2), ex_stat(2));
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [15:0] stim [4];
        logic [5:0]  exp  [4];
        stim[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp[0] = O_IDLE;
        stim[1] = mk(1, 4, 0, 1, 0, 4, 1, 1, 0, 0); exp[1] = O_STALL;
        stim[2] = mk(0, 4, 0, 1, 0, 4, 1, 1, 0, 0); exp[2] = O_IDLE;
        stim[3] = mk(1, 4, 0, 1, 0, 4, 0, 1, 0, 0); exp[3] = O_IDLE;
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL reset_mid cycle %0d: outputs=%b required=%b", i, obs, exp[i]);
            end
            m_step();
        end
        total++;
        if (stall_cycles !== 16'h0 || bubble_count !== 16'h0) begin
            bad++; $display("FAIL reset_mid_stats: stalls=%0d bubbles=%0d required=0 0",
                            stall_cycles, bubble_count);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [5:0]  e;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_step();
        for (int i = 0; i < 600; i++) begin
            v = mk($urandom_range(49, 0) != 0,
                   $urandom_range(7, 0), $urandom_range(7, 0),
                   $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                   $urandom_range(7, 0),
                   $urandom_range(3, 0) != 0, $urandom_range(4, 0) != 0,
                   $urandom_range(5, 0) == 0, $urandom_range(7, 0) == 0);
            // Bias toward matching addresses so stalls happen often.
            if ($urandom_range(1, 0) == 1) v[14:12] = v[6:4];
            apply(v);
            e = m_outs();
            total++;
            if (obs !== e || stall_cycles !== ex_stat(m_stalls) || bubble_count !== ex_stat(m_bubbles)) begin
                bad++; $display("FAIL random cycle %0d in=%h: outputs=%b stalls=%0d bubbles=%0d required=%b %0d %0d",
                                i, v, obs, stall_cycles, bubble_count, e, ex_stat(m_stalls), ex_stat(m_bubbles));
            end
            m_step();
        end
    endtask

    task automatic test_saturation();
        int n;
        n = STATS ? 65534 : 4;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_step();
        // A hazard held continuously keeps stall_active high every cycle.
        for (int i = 0; i < n + 3; i++) begin
            apply(mk(1, 2, 0, 1, 0, 2, 1, 1, 0, 0));
            m_step();
        end
        apply(mk(1, 2, 0, 1, 0, 2, 0, 1, 0, 0));
        total++;
        if (stall_cycles !== ex_stat(SAT_MAX) || bubble_count !== ex_stat(SAT_MAX)) begin
            bad++; $display("FAIL saturation: stalls=%h bubbles=%h required=%h %h",
                            stall_cycles, bubble_count, ex_stat(SAT_MAX), ex_stat(SAT_MAX));
        end
        m_step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_busy();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
